// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller: widths, opcodes,
// FSM states and the instruction word layout.
package alu_issue_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int REG_AW = $clog2(NREGS);
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_LDI = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  // Field order fixes the bit positions: [15:14] op, [13:12] rd,
  // [11:10] rs1, [9:8] rs2, [7:0] imm.
  typedef struct packed {
    opcode_e                 opcode;
    logic [REG_AW-1:0]       rd;
    logic [REG_AW-1:0]       rs1;
    logic [REG_AW-1:0]       rs2;
    logic [DATA_W-1:0]       imm;
  } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file with two registered read ports loaded on
// rd_en, one write port, a combinational debug port and synchronous clear.
module alu_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;

  always_comb begin
    regs_d = regs_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
    if (rd_en) begin
      op_a_d = regs_q[rs1_addr];
      op_b_d = regs_q[rs2_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      regs_q <= regs_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the combinational ALU:
// IDLE accepts, READ fetches operands, EXEC samples the ALU, WRITE retires.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  // valid/ready: an instruction transfers on a rising edge where both
  // instr_valid and instr_ready are high; the source holds instr until then.
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_first,
  output logic [DATA_W-1:0]  alu_second,
  output logic               alu_mul,
  output logic               alu_sub,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               done,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e            state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              done_q, done_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              rd_en;
  logic              wr_en;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    res_d       = res_q;
    done_d      = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    alu_mul     = 1'b0;
    alu_sub     = 1'b0;
    instr_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr_t'(instr);
          // LDI needs no operands, so it skips straight to write-back.
          if (instr_d.opcode == OP_LDI) begin
            res_d   = instr_d.imm;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_sub = (instr_q.opcode == OP_SUB);
        alu_mul = (instr_q.opcode == OP_MUL);
        res_d   = alu_result;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en     = 1'b1;
        done_d    = 1'b1;
        wb_addr_d = instr_q.rd;
        wb_data_d = res_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      res_q     <= res_d;
      done_q    <= done_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Operand registers live in the regfile read ports and hold between uses.
  alu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rs1_addr (instr_q.rs1),
    .rs2_addr (instr_q.rs2),
    .wr_en    (wr_en),
    .wr_addr  (instr_q.rd),
    .wr_data  (res_q),
    .dbg_addr (dbg_addr),
    .op_a     (alu_first),
    .op_b     (alu_second),
    .dbg_data (dbg_data)
  );

  assign done    = done_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random instructions
// checked against an architectural register-file model.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_first;
  logic [7:0]  alu_second;
  logic        alu_mul;
  logic        alu_sub;
  logic [7:0]  alu_result;
  logic        done;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] ref_rf [4];
  logic [7:0] exp_q[$];

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_first   (alu_first),
    .alu_second  (alu_second),
    .alu_mul     (alu_mul),
    .alu_sub     (alu_sub),
    .alu_result  (alu_result),
    .done        (done),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    if (alu_mul)      alu_result = alu_first * alu_second;
    else if (alu_sub) alu_result = alu_first - alu_second;
    else              alu_result = alu_first + alu_second;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction from a negedge in IDLE and follow it to retirement.
  task automatic run(input logic [15:0] ins, input bit hold);
    logic [1:0] op, rd, rs1, rs2;
    logic [7:0] imm, a, b, res, exp_res;
    int lat, exp_lat;
    bit seen;
    op  = ins[15:14];
    rd  = ins[13:12];
    rs1 = ins[11:10];
    rs2 = ins[9:8];
    imm = ins[7:0];
    a   = ref_rf[rs1];
    b   = ref_rf[rs2];
    case (op)
      2'd0:    res = a + b;
      2'd1:    res = a - b;
      2'd2:    res = a * b;
      default: res = imm;
    endcase
    exp_q.push_back(res);
    exp_lat = (op == 2'd3) ? 1 : 3;

    check("ready_idle", 32'(instr_ready), 1);
    instr_valid = 1'b1;
    instr       = ins;
    dbg_addr    = rd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      if (done) seen = 1'b1;
      else begin
        check("ready_busy", 32'(instr_ready), 0);
        if (op != 2'd3 && lat == 1) begin
          check("exec_first", 32'(alu_first), 32'(a));
          check("exec_second", 32'(alu_second), 32'(b));
          check("exec_sub", 32'(alu_sub), 32'(op == 2'd1));
          check("exec_mul", 32'(alu_mul), 32'(op == 2'd2));
        end else begin
          check("ctl_quiet", 32'({alu_mul, alu_sub}), 0);
        end
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    instr_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    exp_res = exp_q.pop_front();
    if (seen) begin
      check("wb_addr", 32'(wb_addr), 32'(rd));
      check("wb_data", 32'(wb_data), 32'(exp_res));
      check("dbg_after_wb", 32'(dbg_data), 32'(exp_res));
      check("ready_at_done", 32'(instr_ready), 1);
    end
    ref_rf[rd] = exp_res;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check(tag, 32'(dbg_data), 32'(ref_rf[i]));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    check("rst_done", 32'(done), 0);
    check("rst_wb_addr", 32'(wb_addr), 0);
    check("rst_wb_data", 32'(wb_data), 0);
    check("rst_first", 32'(alu_first), 0);
    check("rst_second", 32'(alu_second), 0);
    check("rst_ctl", 32'({alu_mul, alu_sub}), 0);
    check("rst_ready", 32'(instr_ready), 1);
    check_regs("rst_regs");
    rst_n = 1'b1;
    @(negedge clk);

    // directed: LDI, ADD in LDI done cycle, SUB, MUL
    run(16'hD00A, 1'b0);
    run(16'hE0FC, 1'b0);
    run(16'h3600, 1'b0);
    check("add_value", 32'(wb_data), 32'h06);
    run(16'h7600, 1'b0);
    check("sub_value", 32'(wb_data), 32'h0E);
    run(16'hB600, 1'b0);
    check("mul_value", 32'(wb_data), 32'hD8);

    // truncated product: 16*16 = 256 -> 0
    run(16'hC010, 1'b0);
    run(16'h8000, 1'b0);
    check("mul_trunc", 32'(wb_data), 32'h00);

    // valid held through busy cycles; one done per instruction
    run(16'h3600, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("done_once", 32'(done), 0);
    run(16'h3600, 1'b1);
    check_regs("regs_after_hold");
    @(negedge clk);

    // reset during EXEC abandons the instruction
    instr_valid = 1'b1;
    instr       = 16'h3600;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_exec_mul", 32'(alu_mul), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) ref_rf[i] = '0;
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_ready", 32'(instr_ready), 1);
    check("rst_mid_ctl", 32'({alu_mul, alu_sub}), 0);
    check("rst_mid_first", 32'(alu_first), 0);
    check_regs("rst_mid_regs");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_done", 32'(done), 0);

    // random instructions with random gaps and hold behaviour
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ins;
      int gap;
      ins = 16'($urandom_range(0, 16'hFFFF));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      run(ins, 1'($urandom_range(0, 1)));
    end
    check_regs("final_regs");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
